pipelined_data_memory: RTL and testbench
========================================

Name: pipelined_data_memory

Overview:
- Parametrised, pipelined word-organised data memory for the RISC-V SiMPLE SV core and its UVM benches.
- Takes byte-addressed read/write requests over a valid/ready handshake and returns one in-order response per request after a configurable latency.
- Supports per-byte write enables and response backpressure.
- Optionally checks addresses against a configured window and flags out-of-range accesses.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8; BE_WIDTH = DATA_WIDTH/8.
- ADDR_BITS, 14, word-address bits; depth = 2**ADDR_BITS words.
- READ_LATENCY, 1, cycles from request acceptance to response valid; legal range 1..4.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_addr  in  32  byte address; low log2(BE_WIDTH) bits ignored
- req_wren  in  1  1 = write, 0 = read
- req_byteena  in  BE_WIDTH  byte lanes written; ignored for reads
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes
- resp_error  out  1  out-of-range access (only with the range-check feature; otherwise tied 0)

Behaviour:
- Word index = (req_addr - BASE_ADDR) >> log2(BE_WIDTH), truncated to ADDR_BITS (modulo wrap) unless range check is enabled.
- Memory array initialised to all zeros at time 0. Reset does NOT clear contents.
- Write: at the acceptance edge, each lane i with req_byteena[i]=1 is updated; other lanes are unchanged.
- Read: word sampled at the acceptance edge, so it reflects all earlier accepted writes. A read accepted the cycle after a write to the same word returns the new data.
- Every accepted request, read or write, yields exactly one response, strictly in order.
- Pipeline: READ_LATENCY stages, each holding valid/rdata/error. The last stage drives the resp_* outputs.
- Stall = resp_valid && !resp_ready. On stall, all stages hold and req_ready=0.
- Otherwise req_ready=1 and the pipeline advances every cycle, bubbles included.
- req_ready depends combinationally on resp_ready. There are no other internal wait states.
- Throughput: 1 request/cycle with resp_ready held high.
- Latency: response valid exactly READ_LATENCY cycles after acceptance, absent stalls.
- Responses held under stall keep resp_rdata/resp_error stable until consumed.
- Reset, including mid-stream: all stage valids=0, resp_valid=0, resp_rdata=0, resp_error=0, req_ready=1 the cycle after reset deasserts.
  - In-flight responses are discarded.
  - A write accepted in the same cycle reset is high is NOT performed; req_ready is forced 0 while reset=1.
- X on req_addr while req_valid=0 is ignored. X while req_valid=1 is a protocol error (SVA flags it).

Optional Feature:
- Macro DATA_MEM_RANGE_CHECK_EN.
- Defined: a request is in range iff BASE_ADDR <= req_addr < BASE_ADDR + depth*BE_WIDTH.
  - Out-of-range write: suppressed; response has resp_error=1.
  - Out-of-range read: resp_rdata=0, resp_error=1.
  - Errors travel with their response through the pipeline and stalls.
- Undefined: no comparison is made; the index wraps modulo depth; resp_error is constant 0.

Decomposition:
- Package data_mem_pkg holds:
  - the response stage struct (valid, rdata, error)
  - localparam helpers BE_WIDTH and the offset-bit computation
  - MAX_READ_LATENCY = 4
- One natural sub-module, data_mem_resp_pipe: parametrised READ_LATENCY stall-able shift pipeline carrying the stage struct.
- Storage array, range check and byte-lane write logic stay in the top module.

Test Plan:
- Write 32'hDEAD_BEEF, byteena 4'hF, to 32'h8000_0010, then read the same address, resp_ready=1, READ_LATENCY=2 -> write response at cycle +2 with rdata 0; read response returns 32'hDEAD_BEEF two cycles after its acceptance.
- Write 32'h1122_3344 with byteena 4'hF, then 32'hAABB_CCDD with byteena 4'b0101 to the same word, then read -> 32'h11BB_33DD.
- Back-to-back reads of 4 distinct words with resp_ready=0 for 3 cycles starting at the first response -> req_ready=0 during the stall, the first response held stable, all 4 responses delivered in order with no loss or duplication.
- With DATA_MEM_RANGE_CHECK_EN, depth 2**14: write to 32'h8001_0000, then read 32'h8001_0000 -> both responses carry resp_error=1, the read returns 0, word 0 is unchanged. Without the macro, the same write aliases to word 0.
- Assert reset for 1 cycle with 2 reads in flight -> resp_valid=0 the following cycle, no stale responses afterwards, and previously written memory contents are still readable.
- Read an unwritten address 32'h8000_0100 after reset -> resp_rdata=32'h0000_0000, resp_error=0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared stage type, lane/offset helpers and latency limit for pipelined_data_memory
package data_mem_pkg;
   localparam int MAX_READ_LATENCY   = 4;
   localparam int DEFAULT_DATA_WIDTH = 32;
   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction
   function automatic int offset_bits(input int data_width);
      return $clog2(data_width / 8);
   endfunction
   typedef struct packed {
      logic                          valid;
      logic [DEFAULT_DATA_WIDTH-1:0] rdata;
      logic                          error;
   } resp_stage_t;
endpackage

// File: rtl/data_mem_resp_pipe.sv
// data_mem_resp_pipe: stall-able READ_LATENCY-deep shift pipeline of response stages
module data_mem_resp_pipe
   import data_mem_pkg::*;
#(
   parameter int  READ_LATENCY = 1,
   parameter type stage_t      = resp_stage_t
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   stall,
   input  stage_t din,
   output stage_t dout
);
   stage_t stage [READ_LATENCY];
   if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
      $error("READ_LATENCY must be within 1..MAX_READ_LATENCY");
   end
   always_ff @(posedge clock) begin
      if (reset) stage <= '{default: '0};
      else if (!stall) begin
         stage[0] <= din;
         for (int i = 1; i < READ_LATENCY; i++) stage[i] <= stage[i-1];
      end
   end
   assign dout = stage[READ_LATENCY-1];
endmodule

// File: rtl/pipelined_data_memory.sv
// pipelined_data_memory: byte-addressed word memory, valid/ready requests, in-order responses.
// Define DATA_MEM_RANGE_CHECK_EN to flag and suppress accesses outside the memory window.
module pipelined_data_memory
   import data_mem_pkg::*;
#(
   parameter int          DATA_WIDTH   = 32,
   parameter int          ADDR_BITS    = 14,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [31:0]                   req_addr,
   input  logic                          req_wren,
   input  logic [DATA_WIDTH/8-1:0]       req_byteena,
   input  logic [DATA_WIDTH-1:0]         req_wdata,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [DATA_WIDTH-1:0]         resp_rdata,
   output logic                          resp_error
);
   localparam int BE_WIDTH = be_width(DATA_WIDTH);
   localparam int OFFS     = offset_bits(DATA_WIDTH);
   localparam int DEPTH    = 1 << ADDR_BITS;
   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] rdata;
      logic                  error;
   } stage_t;
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
   logic [31:0]           offset;
   logic [ADDR_BITS-1:0]  widx;
   logic                  in_range, stall, accept;
   stage_t                pipe_in, pipe_out;
   assign offset = req_addr - BASE_ADDR;
   assign widx   = ADDR_BITS'(offset >> OFFS);
`ifdef DATA_MEM_RANGE_CHECK_EN
   assign in_range = (req_addr >= BASE_ADDR) && ((offset >> (OFFS + ADDR_BITS)) == '0);
`else
   assign in_range = 1'b1;
`endif
   // A held response freezes the whole pipe, so new requests must wait with it.
   assign stall     = pipe_out.valid && !resp_ready;
   assign req_ready = !reset && !stall;
   assign accept    = req_valid && req_ready;
   always_ff @(posedge clock) begin
      for (int i = 0; i < BE_WIDTH; i++)
         if (accept && req_wren && in_range && req_byteena[i]) mem[widx][8*i +: 8] <= req_wdata[8*i +: 8];
   end
   always_comb begin
      pipe_in.valid = accept;
      pipe_in.rdata = (req_wren || !in_range) ? '0 : mem[widx];
      pipe_in.error = accept && !in_range;
   end
   data_mem_resp_pipe #(
      .READ_LATENCY (READ_LATENCY),
      .stage_t      (stage_t)
   ) u_pipe (
      .clock (clock),
      .reset (reset),
      .stall (stall),
      .din   (pipe_in),
      .dout  (pipe_out)
   );
   assign resp_valid = pipe_out.valid;
   assign resp_rdata = pipe_out.rdata;
   assign resp_error = pipe_out.error;
   a_addr_known: assert property (@(posedge clock) disable iff (reset) req_valid |-> !$isunknown(req_addr));
endmodule

// File: tb/tb_pipelined_data_memory.sv
// tb_pipelined_data_memory: directed and random traffic checked against a queue/array model
module tb_pipelined_data_memory;
   localparam int          LAT   = 2;
   localparam int          AB    = 14;
   localparam int          DEPTH = 1 << AB;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   logic        clock = 0, reset = 1, req_valid = 0, req_wren = 0, resp_ready = 1;
   logic        req_ready, resp_valid, resp_error;
   logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata;
   logic [3:0]  req_byteena = 0;
   int          n_chk = 0, n_fail = 0;
   bit          live = 0;
   typedef struct {logic [31:0] d; logic e; int age;} ent_t;
   ent_t        q[$];
   ent_t        log_q[$];
   logic [31:0] mm [int];
   always #5 clock = ~clock;
   pipelined_data_memory #(
      .DATA_WIDTH   (32),
      .ADDR_BITS    (AB),
      .READ_LATENCY (LAT),
      .BASE_ADDR    (BASE)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_wren    (req_wren),
      .req_byteena (req_byteena),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_error  (resp_error)
   );
   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endfunction
   function automatic bit in_rng(logic [31:0] a);
`ifdef DATA_MEM_RANGE_CHECK_EN
      return longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + longint'(DEPTH) * 4;
`else
      return !$isunknown(a);
`endif
   endfunction
   function automatic int widx(logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'(off >> 2) % DEPTH;
   endfunction
   function automatic logic [31:0] mread(logic [31:0] a);
      int i;
      i = widx(a);
      return mm.exists(i) ? mm[i] : 32'h0;
   endfunction
   function automatic void chk_log(int i, logic [31:0] d, logic e, string nm);
      if (i >= log_q.size()) chk({nm, "_missing"}, 32'(log_q.size()), 32'(i + 1));
      else begin
         chk({nm, "_rdata"}, log_q[i].d, d);
         chk({nm, "_error"}, 32'(log_q[i].e), 32'(e));
      end
   endfunction
   // Model: each accepted request waits LAT unstalled edges, then shows at the head in order.
   always @(negedge clock) begin
      bit          exp_valid, stall, ok;
      ent_t        n;
      logic [31:0] w;
      exp_valid = q.size() > 0 && q[0].age >= LAT;
      stall     = exp_valid && !resp_ready;
      if (live) begin
         chk("req_ready", 32'(req_ready), 32'(!reset && !stall));
         chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
         if (exp_valid) begin
            chk("resp_rdata", resp_rdata, q[0].d);
            chk("resp_error", 32'(resp_error), 32'(q[0].e));
         end
      end
      if (resp_valid && resp_ready && !reset) log_q.push_back('{resp_rdata, resp_error, 0});
      if (reset) begin
         q.delete();
         live = 1;
      end else if (live && !stall) begin
         if (exp_valid) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (req_valid) begin
            ok = in_rng(req_addr);
            n.e = !ok;
            n.age = 1;
            n.d = 32'h0;
            if (!req_wren && ok) n.d = mread(req_addr);
            if (req_wren && ok) begin
               w = mread(req_addr);
               for (int b = 0; b < 4; b++) if (req_byteena[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
               mm[widx(req_addr)] = w;
            end
            q.push_back(n);
         end
      end
   end
   task automatic send(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
      bit acc;
      acc = 0;
      req_valid = 1; req_addr = a; req_wren = w; req_byteena = be; req_wdata = d;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clock);
         acc = req_ready;
         @(posedge clock);
         #1;
      end
      chk("send_accept", 32'(acc), 32'd1);
      req_valid = 0;
   endtask
   task automatic wait_log(input int n, input string nm);
      for (int k = 0; k < 50 && log_q.size() < n; k++) begin
         @(posedge clock);
         #1;
      end
      repeat (LAT + 2) @(posedge clock);
      #1;
      chk(nm, 32'(log_q.size()), 32'(n));
   endtask
   function automatic logic [31:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if (r == 8) return 32'h8001_0000 + 32'(4 * $urandom_range(0, 15));
      return $urandom_range(0, 1) ? BASE - 32'd4 : BASE + 32'(DEPTH * 4 - 4);
   endfunction
   initial begin
      bit acc;
      acc = 0;
      repeat (2) @(posedge clock);
      #1;
      reset = 0;
      #1;
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      log_q.delete();
      send(32'h8000_0100, 0, 4'hF, 32'h0);
      wait_log(1, "unwritten_cnt");
      chk_log(0, 32'h0, 1'b0, "unwritten");
      log_q.delete();
      send(32'h8000_0010, 1, 4'hF, 32'hDEAD_BEEF);
      send(32'h8000_0010, 0, 4'h0, 32'h0);
      chk("t1_wr_resp_valid", 32'(resp_valid), 32'd1);
      chk("t1_wr_resp_rdata", resp_rdata, 32'h0);
      @(posedge clock);
      #1;
      chk("t1_rd_resp_valid", 32'(resp_valid), 32'd1);
      chk("t1_rd_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
      wait_log(2, "t1_cnt");
      chk_log(0, 32'h0, 1'b0, "t1_write");
      chk_log(1, 32'hDEAD_BEEF, 1'b0, "t1_read");
      log_q.delete();
      send(32'h8000_0040, 1, 4'hF, 32'h1122_3344);
      send(32'h8000_0040, 1, 4'b0101, 32'hAABB_CCDD);
      send(32'h8000_0040, 0, 4'h0, 32'h0);
      wait_log(3, "t2_cnt");
      chk_log(2, 32'h11BB_33DD, 1'b0, "t2_merge");
      chk("t2_model_pin", mread(32'h8000_0040), 32'h11BB_33DD);
      log_q.delete();
      send(32'h8001_0000, 1, 4'hF, 32'hCAFE_F00D);
      send(32'h8001_0000, 0, 4'h0, 32'h0);
      send(32'h8000_0000, 0, 4'h0, 32'h0);
      wait_log(3, "t4_cnt");
`ifdef DATA_MEM_RANGE_CHECK_EN
      chk_log(0, 32'h0, 1'b1, "t4_oor_write");
      chk_log(1, 32'h0, 1'b1, "t4_oor_read");
      chk_log(2, 32'h0, 1'b0, "t4_word0");
`else
      chk_log(0, 32'h0, 1'b0, "t4_alias_write");
      chk_log(1, 32'hCAFE_F00D, 1'b0, "t4_alias_read");
      chk_log(2, 32'hCAFE_F00D, 1'b0, "t4_word0");
`endif
      for (int k = 0; k < 4; k++) send(32'h8000_0080 + 32'(4 * k), 1, 4'hF, 32'h5500_0000 + 32'(k));
      wait_log(7, "t3_prep_cnt");
      log_q.delete();
      fork
         for (int k = 0; k < 4; k++) send(32'h8000_0080 + 32'(4 * k), 0, 4'h0, 32'h0);
         begin
            for (int k = 0; k < 20 && !resp_valid; k++) begin
               @(posedge clock);
               #1;
            end
            resp_ready = 0;
            for (int k = 0; k < 3; k++) begin
               #1;
               chk("t3_stall_ready", 32'(req_ready), 32'd0);
               chk("t3_stall_rdata", resp_rdata, 32'h5500_0000);
               @(posedge clock);
            end
            #1;
            resp_ready = 1;
         end
      join
      wait_log(4, "t3_cnt");
      for (int k = 0; k < 4; k++) chk_log(k, 32'h5500_0000 + 32'(k), 1'b0, "t3_order");
      log_q.delete();
      req_valid = 1; req_wren = 0; req_addr = 32'h8000_0010;
      @(posedge clock);
      #1;
      req_addr = 32'h8000_0040;
      @(posedge clock);
      #1;
      reset = 1; req_wren = 1; req_addr = 32'h8000_0010; req_byteena = 4'hF; req_wdata = 32'h0;
      @(posedge clock);
      #1;
      reset = 0; req_valid = 0;
      #1;
      chk("t5_resp_valid", 32'(resp_valid), 32'd0);
      chk("t5_req_ready", 32'(req_ready), 32'd1);
      repeat (6) @(posedge clock);
      #1;
      chk("t5_no_stale", 32'(log_q.size()), 32'd0);
      send(32'h8000_0010, 0, 4'h0, 32'h0);
      wait_log(1, "t5_cnt");
      chk_log(0, 32'hDEAD_BEEF, 1'b0, "t5_kept");
      for (int c = 0; c < 3000; c++) begin
         if (!req_valid || acc) begin
            req_valid   = $urandom_range(0, 3) != 0;
            req_wren    = 1'($urandom_range(0, 1));
            req_addr    = pick_addr();
            req_byteena = 4'($urandom);
            req_wdata   = $urandom;
         end
         resp_ready = $urandom_range(0, 3) != 0;
         reset      = $urandom_range(0, 299) == 0;
         @(negedge clock);
         acc = req_valid && req_ready;
         @(posedge clock);
         #1;
      end
      reset = 0; req_valid = 0; resp_ready = 1;
      repeat (10) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
